cv32e40p_register_file_ecc_scrub: RTL and testbench

//  SECDED-protected RISC-V integer register file: 3 combinational read ports, 2 write ports.
//  A background scrubber walks all registers, rewrites single-bit-corrected words and counts

---
 rtl/cv32e40p_register_file_ecc_scrub_if.sv | 48 ++++
 rtl/cv32e40p_register_file_ecc_scrub.sv | 210 +++++++++++++++++++++
 tb/tb_cv32e40p_register_file_ecc_scrub.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_register_file_ecc_scrub_if.sv
// Register file bus: read, write, scrub control/status and fault-injection signals.
// The ECC width is derived here so the injection mask always covers the full stored codeword.
interface cv32e40p_register_file_ecc_scrub_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    // Hamming check bits plus one overall parity bit
    function automatic int calc_ecc_width(int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r + 1;
    endfunction

    localparam int ECC_WIDTH = calc_ecc_width(DATA_WIDTH);

    logic [ADDR_WIDTH-1:0]           raddr_a_i, raddr_b_i, raddr_c_i;
    logic [DATA_WIDTH-1:0]           rdata_a_o, rdata_b_o, rdata_c_o;
    logic [2:0]                      err_single_o, err_double_o;
    logic [ADDR_WIDTH-1:0]           waddr_a_i, waddr_b_i;
    logic [DATA_WIDTH-1:0]           wdata_a_i, wdata_b_i;
    logic                            we_a_i, we_b_i;
    logic                            scrub_en_i, scrub_req_i, scrub_busy_o;
    logic [CNT_WIDTH-1:0]            sec_cnt_o, ded_cnt_o;
    logic                            ded_irq_o;
    logic                            inj_en_i;
    logic [ADDR_WIDTH-1:0]           inj_addr_i;
    logic [DATA_WIDTH+ECC_WIDTH-1:0] inj_mask_i;

    modport master (
        output raddr_a_i, raddr_b_i, raddr_c_i,
        input  rdata_a_o, rdata_b_o, rdata_c_o, err_single_o, err_double_o,
        output waddr_a_i, waddr_b_i, wdata_a_i, wdata_b_i, we_a_i, we_b_i,
        output scrub_en_i, scrub_req_i,
        input  scrub_busy_o, sec_cnt_o, ded_cnt_o, ded_irq_o,
        output inj_en_i, inj_addr_i, inj_mask_i
    );

    modport slave (
        input  raddr_a_i, raddr_b_i, raddr_c_i,
        output rdata_a_o, rdata_b_o, rdata_c_o, err_single_o, err_double_o,
        input  waddr_a_i, waddr_b_i, wdata_a_i, wdata_b_i, we_a_i, we_b_i,
        input  scrub_en_i, scrub_req_i,
        output scrub_busy_o, sec_cnt_o, ded_cnt_o, ded_irq_o,
        input  inj_en_i, inj_addr_i, inj_mask_i
    );
endinterface

// File: rtl/cv32e40p_register_file_ecc_scrub.sv
// SECDED register file (3R/2W) with a background scrubber that rewrites corrected words
// and counts uncorrectable ones. Codeword layout is {ecc, data}; ecc MSB is overall parity.
module cv32e40p_register_file_ecc_scrub #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WORDS      = 32,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input logic clk,
    input logic rst,
    cv32e40p_register_file_ecc_scrub_if.slave rf
);
    function automatic int calc_r(int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    localparam int R         = calc_r(DATA_WIDTH);
    localparam int ECC_WIDTH = R + 1;
    localparam int N         = DATA_WIDTH + R;
    localparam int CW        = DATA_WIDTH + ECC_WIDTH;
    localparam int IW        = $clog2(SCRUB_INTERVAL) + 1;
    localparam logic [IW-1:0]         IVL_LAST = IW'(SCRUB_INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   NW       = (ADDR_WIDTH+1)'(NUM_WORDS);

    typedef struct packed {
        logic                  single;
        logic                  dbl;
        logic [DATA_WIDTH-1:0] data;
    } dec_t;

    typedef enum logic [1:0] {IDLE, READ, WB, NEXT} state_e;

    // Data bits occupy the non-power-of-two Hamming positions 1..N in ascending order
    function automatic logic [ECC_WIDTH-1:0] ecc_enc(logic [DATA_WIDTH-1:0] d);
        logic [ECC_WIDTH-1:0] e;
        int di;
        e  = '0;
        di = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int j = 0; j < R; j++) if (p[j]) e[j] = e[j] ^ d[di];
                di++;
            end
        end
        e[R] = ^{e[R-1:0], d};
        return e;
    endfunction

    function automatic logic [CW-1:0] ecc_cw(logic [DATA_WIDTH-1:0] d);
        return {ecc_enc(d), d};
    endfunction

    function automatic dec_t ecc_dec(logic [CW-1:0] cw);
        dec_t                  r;
        logic [DATA_WIDTH-1:0] d;
        logic [ECC_WIDTH-1:0]  e;
        logic [R-1:0]          s;
        logic                  par;
        int                    di;
        d   = cw[DATA_WIDTH-1:0];
        e   = ecc_enc(d);
        s   = e[R-1:0] ^ cw[DATA_WIDTH +: R];
        par = ^cw;
        // odd parity with a syndrome past the last position can only be a multi-bit error
        r.single = par && (int'(s) <= N);
        r.dbl    = (!par && s != '0) || (par && int'(s) > N);
        di = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (par && p == int'(s)) d[di] = ~d[di];
                di++;
            end
        end
        r.data = d;
        return r;
    endfunction

    logic [CW-1:0]             mem [NUM_WORDS];
    logic [2:0][ADDR_WIDTH-1:0] raddr;
    dec_t [2:0]                rd_dec;
    dec_t                      scr_dec;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [IW-1:0]         ivl_q, ivl_d;
    logic [CW-1:0]         corr_q;
    logic                  wr_hit_q, wr_ptr;
    logic                  scrub_wr, sec_inc, ded_inc, ded_irq_q;
    logic [CNT_WIDTH-1:0]  sec_cnt_q, ded_cnt_q;

    // Read ports: index 2/1/0 = a/b/c, matching the flag bit order
    assign raddr = {rf.raddr_a_i, rf.raddr_b_i, rf.raddr_c_i};

    always_comb begin
        for (int k = 0; k < 3; k++)
            rd_dec[k] = ecc_dec((raddr[k] != '0 && {1'b0, raddr[k]} < NW) ? mem[raddr[k]] : '0);
    end

    assign rf.rdata_a_o    = rd_dec[2].data;
    assign rf.rdata_b_o    = rd_dec[1].data;
    assign rf.rdata_c_o    = rd_dec[0].data;
    assign rf.err_single_o = {rd_dec[2].single, rd_dec[1].single, rd_dec[0].single};
    assign rf.err_double_o = {rd_dec[2].dbl, rd_dec[1].dbl, rd_dec[0].dbl};

    // Per-word priority: port b > port a > scrub writeback > injection; x0 stays zero
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (rst || w == 0)
                mem[w] <= '0;
            else if (rf.we_b_i && rf.waddr_b_i == ADDR_WIDTH'(w))
                mem[w] <= ecc_cw(rf.wdata_b_i);
            else if (rf.we_a_i && rf.waddr_a_i == ADDR_WIDTH'(w))
                mem[w] <= ecc_cw(rf.wdata_a_i);
            else if (scrub_wr && ptr_q == ADDR_WIDTH'(w))
                mem[w] <= corr_q;
            else if (rf.inj_en_i && rf.inj_addr_i == ADDR_WIDTH'(w))
                mem[w] <= mem[w] ^ rf.inj_mask_i;
        end
    end

    assign scr_dec = ecc_dec(mem[ptr_q]);
    assign wr_ptr  = (rf.we_a_i && rf.waddr_a_i == ptr_q) || (rf.we_b_i && rf.waddr_b_i == ptr_q);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ivl_d    = ivl_q;
        scrub_wr = 1'b0;
        sec_inc  = 1'b0;
        ded_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                // a manual request also restarts the idle interval
                if (rf.scrub_req_i) begin
                    state_d = READ;
                    ivl_d   = '0;
                end else if (rf.scrub_en_i) begin
                    if (ivl_q == IVL_LAST) begin
                        state_d = READ;
                        ivl_d   = '0;
                    end else begin
                        ivl_d = ivl_q + 1'b1;
                    end
                end
            end
            READ: begin
                if (scr_dec.single) state_d = WB;
                else begin
                    state_d = NEXT;
                    ded_inc = scr_dec.dbl;
                end
            end
            WB: begin
                // a port write to this word since READ makes the corrected copy stale
                if (wr_hit_q || wr_ptr) state_d = NEXT;
                else if (!(rf.we_a_i || rf.we_b_i)) begin
                    scrub_wr = 1'b1;
                    sec_inc  = 1'b1;
                    state_d  = NEXT;
                end
            end
            NEXT: begin
                if (ptr_q == PTR_LAST) begin
                    ptr_d   = ADDR_WIDTH'(1);
                    state_d = IDLE;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= ADDR_WIDTH'(1);
            ivl_q     <= '0;
            corr_q    <= '0;
            wr_hit_q  <= 1'b0;
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
            ded_irq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ivl_q     <= ivl_d;
            ded_irq_q <= ded_inc;
            if (state_q == READ) begin
                corr_q   <= ecc_cw(scr_dec.data);
                wr_hit_q <= wr_ptr;
            end else if (state_q == WB) begin
                wr_hit_q <= wr_hit_q | wr_ptr;
            end
            if (sec_inc && !(&sec_cnt_q)) sec_cnt_q <= sec_cnt_q + 1'b1;
            if (ded_inc && !(&ded_cnt_q)) ded_cnt_q <= ded_cnt_q + 1'b1;
        end
    end

    assign rf.scrub_busy_o = (state_q != IDLE);
    assign rf.sec_cnt_o    = sec_cnt_q;
    assign rf.ded_cnt_o    = ded_cnt_q;
    assign rf.ded_irq_o    = ded_irq_q;
endmodule

// File: tb/tb_cv32e40p_register_file_ecc_scrub.sv
// Self-checking bench: directed scrub/ECC scenarios plus randomized traffic checked against
// a model that tracks each register's true value and the set of bits flipped in its codeword.
module tb_cv32e40p_register_file_ecc_scrub;
    localparam int AW = 5, DW = 32, CW = 39, CNTW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cv32e40p_register_file_ecc_scrub_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CNTW)) rf ();

    cv32e40p_register_file_ecc_scrub #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(32), .SCRUB_INTERVAL(1024), .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rf (rf)
    );

    task automatic clear_inputs();
        rf.raddr_a_i = '0; rf.raddr_b_i = '0; rf.raddr_c_i = '0;
        rf.waddr_a_i = '0; rf.waddr_b_i = '0; rf.wdata_a_i = '0; rf.wdata_b_i = '0;
        rf.we_a_i = 1'b0; rf.we_b_i = 1'b0;
        rf.scrub_en_i = 1'b0; rf.scrub_req_i = 1'b0;
        rf.inj_en_i = 1'b0; rf.inj_addr_i = '0; rf.inj_mask_i = '0;
    endtask

    task automatic set_raddr(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
        rf.raddr_a_i = a; rf.raddr_b_i = b; rf.raddr_c_i = c;
        #1;
    endtask

    task automatic write_port(input bit port_b, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        if (port_b) begin rf.we_b_i = 1'b1; rf.waddr_b_i = a; rf.wdata_b_i = d; end
        else        begin rf.we_a_i = 1'b1; rf.waddr_a_i = a; rf.wdata_a_i = d; end
        @(negedge clk);
        rf.we_a_i = 1'b0; rf.we_b_i = 1'b0;
    endtask

    task automatic inject(input logic [AW-1:0] a, input logic [CW-1:0] m);
        @(negedge clk);
        rf.inj_en_i = 1'b1; rf.inj_addr_i = a; rf.inj_mask_i = m;
        @(negedge clk);
        rf.inj_en_i = 1'b0; rf.inj_mask_i = '0;
    endtask

    // Starts a pass; returns whether busy rose, busy cycles, irq pulses, and timeout
    task automatic run_pass(output bit busy0, output int cyc, output int irqs, output bit tmo);
        @(negedge clk);
        rf.scrub_req_i = 1'b1;
        @(negedge clk);
        rf.scrub_req_i = 1'b0;
        busy0 = rf.scrub_busy_o;
        cyc = 0; irqs = 0;
        while (rf.scrub_busy_o && cyc < 400) begin
            if (rf.ded_irq_o) irqs++;
            cyc++;
            @(negedge clk);
        end
        tmo = (cyc >= 400);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        set_raddr(5'd0, 5'd5, 5'd31);
        tests++; if (rf.scrub_busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", rf.scrub_busy_o); end
        tests++; if (rf.sec_cnt_o !== '0 || rf.ded_cnt_o !== '0 || rf.ded_irq_o !== 1'b0) begin
            fails++; $display("FAIL reset_cnt sec=%0d ded=%0d irq=%b exp=0/0/0", rf.sec_cnt_o, rf.ded_cnt_o, rf.ded_irq_o); end
        tests++; if ({rf.rdata_a_o, rf.rdata_b_o, rf.rdata_c_o} !== '0 || rf.err_single_o !== 3'b0 || rf.err_double_o !== 3'b0) begin
            fails++; $display("FAIL reset_reads a=%h b=%h c=%h s=%b d=%b exp=0", rf.rdata_a_o, rf.rdata_b_o, rf.rdata_c_o, rf.err_single_o, rf.err_double_o); end
    endtask

    task automatic test_write_read();
        write_port(1'b0, 5'd5, 32'hDEADBEEF);
        set_raddr(5'd5, 5'd0, 5'd0);
        tests++; if (rf.rdata_a_o !== 32'hDEADBEEF || rf.err_single_o !== 3'b0 || rf.err_double_o !== 3'b0) begin
            fails++; $display("FAIL write_read data=%h s=%b d=%b exp=deadbeef/000/000", rf.rdata_a_o, rf.err_single_o, rf.err_double_o); end
    endtask

    task automatic test_inject_single();
        inject(5'd5, 39'd1 << 3);
        set_raddr(5'd0, 5'd5, 5'd0);
        tests++; if (rf.rdata_b_o !== 32'hDEADBEEF || rf.err_single_o !== 3'b010 || rf.err_double_o !== 3'b0) begin
            fails++; $display("FAIL inj_single data=%h s=%b d=%b exp=deadbeef/010/000", rf.rdata_b_o, rf.err_single_o, rf.err_double_o); end
        tests++; if (rf.sec_cnt_o !== '0) begin fails++; $display("FAIL inj_no_count sec=%0d exp=0", rf.sec_cnt_o); end
    endtask

    task automatic test_scrub_single();
        bit b0, tmo; int cyc, irqs;
        run_pass(b0, cyc, irqs, tmo);
        tests++; if (b0 !== 1'b1) begin fails++; $display("FAIL scrub_busy got=%b exp=1", b0); end
        tests++; if (tmo || cyc != 63) begin fails++; $display("FAIL scrub_single_len got=%0d exp=63", cyc); end
        tests++; if (rf.sec_cnt_o !== 16'd1 || rf.ded_cnt_o !== 16'd0 || irqs != 0) begin
            fails++; $display("FAIL scrub_single_cnt sec=%0d ded=%0d irqs=%0d exp=1/0/0", rf.sec_cnt_o, rf.ded_cnt_o, irqs); end
        set_raddr(5'd5, 5'd5, 5'd5);
        tests++; if (rf.rdata_c_o !== 32'hDEADBEEF || rf.err_single_o !== 3'b0 || rf.err_double_o !== 3'b0) begin
            fails++; $display("FAIL scrub_fixed data=%h s=%b d=%b exp=deadbeef/000/000", rf.rdata_c_o, rf.err_single_o, rf.err_double_o); end
    endtask

    task automatic test_double();
        bit b0, tmo; int cyc, irqs;
        write_port(1'b1, 5'd7, 32'h0BAD_F00D);
        inject(5'd7, 39'h3);
        set_raddr(5'd0, 5'd0, 5'd7);
        tests++; if (rf.err_double_o !== 3'b001 || rf.err_single_o !== 3'b0) begin
            fails++; $display("FAIL dbl_read s=%b d=%b exp=000/001", rf.err_single_o, rf.err_double_o); end
        run_pass(b0, cyc, irqs, tmo);
        tests++; if (tmo || cyc != 62) begin fails++; $display("FAIL dbl_pass_len got=%0d exp=62", cyc); end
        tests++; if (rf.ded_cnt_o !== 16'd1 || rf.sec_cnt_o !== 16'd1 || irqs != 1) begin
            fails++; $display("FAIL dbl_cnt ded=%0d sec=%0d irqs=%0d exp=1/1/1", rf.ded_cnt_o, rf.sec_cnt_o, irqs); end
        set_raddr(5'd7, 5'd0, 5'd0);
        tests++; if (rf.err_double_o !== 3'b100) begin fails++; $display("FAIL dbl_not_rewritten d=%b exp=100", rf.err_double_o); end
    endtask

    task automatic test_priority();
        int cyc;
        @(negedge clk);
        rf.we_a_i = 1'b1; rf.waddr_a_i = 5'd9; rf.wdata_a_i = 32'h1111;
        rf.we_b_i = 1'b1; rf.waddr_b_i = 5'd9; rf.wdata_b_i = 32'h2222;
        @(negedge clk);
        rf.we_a_i = 1'b0; rf.we_b_i = 1'b0;
        set_raddr(5'd9, 5'd0, 5'd0);
        tests++; if (rf.rdata_a_o !== 32'h2222) begin fails++; $display("FAIL prio_b_over_a got=%h exp=2222", rf.rdata_a_o); end
        // x4 carries a single error; port a overwrites it during the scrubber's WB cycle
        write_port(1'b0, 5'd4, 32'hA5A5A5A5);
        inject(5'd4, 39'd1 << 10);
        @(negedge clk);
        rf.scrub_req_i = 1'b1;
        @(negedge clk);
        rf.scrub_req_i = 1'b0;
        repeat (7) @(negedge clk);
        rf.we_a_i = 1'b1; rf.waddr_a_i = 5'd4; rf.wdata_a_i = 32'h5A5A5A5A;
        @(negedge clk);
        rf.we_a_i = 1'b0;
        cyc = 0;
        while (rf.scrub_busy_o && cyc < 400) begin cyc++; @(negedge clk); end
        tests++; if (cyc >= 400) begin fails++; $display("FAIL wb_pass_timeout cycles=%0d", cyc); end
        set_raddr(5'd4, 5'd0, 5'd0);
        tests++; if (rf.rdata_a_o !== 32'h5A5A5A5A || rf.err_single_o !== 3'b0) begin
            fails++; $display("FAIL wb_collision data=%h s=%b exp=5a5a5a5a/000", rf.rdata_a_o, rf.err_single_o); end
        tests++; if (rf.sec_cnt_o !== 16'd1) begin fails++; $display("FAIL wb_cancel_cnt sec=%0d exp=1", rf.sec_cnt_o); end
    endtask

    task automatic test_reset_mid();
        inject(5'd1, 39'd1 << 20);
        @(negedge clk);
        rf.scrub_req_i = 1'b1;
        @(negedge clk);
        rf.scrub_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_raddr(5'd1, 5'd5, 5'd9);
        tests++; if (rf.scrub_busy_o !== 1'b0 || rf.sec_cnt_o !== '0 || rf.ded_cnt_o !== '0 || rf.ded_irq_o !== 1'b0) begin
            fails++; $display("FAIL rst_mid_state busy=%b sec=%0d ded=%0d irq=%b exp=0", rf.scrub_busy_o, rf.sec_cnt_o, rf.ded_cnt_o, rf.ded_irq_o); end
        tests++; if ({rf.rdata_a_o, rf.rdata_b_o, rf.rdata_c_o} !== '0 || rf.err_single_o !== 3'b0 || rf.err_double_o !== 3'b0) begin
            fails++; $display("FAIL rst_mid_reads a=%h b=%h c=%h s=%b d=%b exp=0", rf.rdata_a_o, rf.rdata_b_o, rf.rdata_c_o, rf.err_single_o, rf.err_double_o); end
        rst = 1'b0;
        write_port(1'b0, 5'd0, 32'hFFFF_FFFF);
        set_raddr(5'd0, 5'd0, 5'd0);
        tests++; if (rf.rdata_a_o !== '0 || rf.err_single_o !== 3'b0) begin fails++; $display("FAIL x0_write got=%h exp=0", rf.rdata_a_o); end
    endtask

    task automatic test_periodic();
        int cyc;
        rf.scrub_en_i = 1'b1;
        repeat (1023) @(negedge clk);
        tests++; if (rf.scrub_busy_o !== 1'b0) begin fails++; $display("FAIL periodic_early busy=%b exp=0", rf.scrub_busy_o); end
        @(negedge clk);
        tests++; if (rf.scrub_busy_o !== 1'b1) begin fails++; $display("FAIL periodic_start busy=%b exp=1", rf.scrub_busy_o); end
        rf.scrub_en_i = 1'b0;
        cyc = 0;
        while (rf.scrub_busy_o && cyc < 400) begin cyc++; @(negedge clk); end
        tests++; if (cyc != 62) begin fails++; $display("FAIL periodic_pass_len got=%0d exp=62", cyc); end
    endtask

    task automatic test_random();
        logic [DW-1:0] md [32];
        logic [CW-1:0] mm [32];
        logic [AW-1:0] ra [3];
        logic [AW-1:0] wa, wb, ia;
        logic [DW-1:0] da, db, got, ed;
        logic [CW-1:0] im;
        logic [2:0]    es, edb;
        bit            wea, web, ien;
        int            pc, b0;
        for (int i = 0; i < 32; i++) begin md[i] = '0; mm[i] = '0; end
        repeat (300) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) ra[p] = AW'($urandom_range(0, 31));
            wea = ($urandom_range(0, 2) == 0); wa = AW'($urandom_range(0, 31)); da = $urandom;
            web = ($urandom_range(0, 3) == 0); wb = AW'($urandom_range(0, 31)); db = $urandom;
            ia = AW'($urandom_range(0, 31)); ien = 1'b0; im = '0;
            if ($urandom_range(0, 2) == 0 && $countones(mm[ia]) < 2) begin
                do b0 = $urandom_range(0, CW - 1); while (mm[ia][b0]);
                im = CW'(1) << b0; ien = 1'b1;
            end
            rf.raddr_a_i = ra[0]; rf.raddr_b_i = ra[1]; rf.raddr_c_i = ra[2];
            rf.we_a_i = wea; rf.waddr_a_i = wa; rf.wdata_a_i = da;
            rf.we_b_i = web; rf.waddr_b_i = wb; rf.wdata_b_i = db;
            rf.inj_en_i = ien; rf.inj_addr_i = ia; rf.inj_mask_i = im;
            #1;
            es = '0; edb = '0;
            for (int p = 0; p < 3; p++) begin
                ed = '0; pc = 0;
                if (ra[p] != '0) begin ed = md[ra[p]]; pc = $countones(mm[ra[p]]); end
                es[2-p] = (pc == 1); edb[2-p] = (pc == 2);
                got = (p == 0) ? rf.rdata_a_o : (p == 1) ? rf.rdata_b_o : rf.rdata_c_o;
                if (pc != 2) begin
                    tests++; if (got !== ed) begin fails++; $display("FAIL rand_data port=%0d addr=%0d got=%h exp=%h", p, ra[p], got, ed); end
                end
            end
            tests++; if (rf.err_single_o !== es || rf.err_double_o !== edb) begin
                fails++; $display("FAIL rand_flags s=%b d=%b exp=%b/%b", rf.err_single_o, rf.err_double_o, es, edb); end
            if (ien && ia != '0) mm[ia] = mm[ia] ^ im;
            if (wea && wa != '0) begin md[wa] = da; mm[wa] = '0; end
            if (web && wb != '0) begin md[wb] = db; mm[wb] = '0; end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        tests++; if (rf.sec_cnt_o !== '0 || rf.ded_cnt_o !== '0) begin
            fails++; $display("FAIL rand_reads_no_count sec=%0d ded=%0d exp=0/0", rf.sec_cnt_o, rf.ded_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_inject_single();
        test_scrub_single();
        test_double();
        test_priority();
        test_reset_mid();
        test_periodic();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
